// File: rtl/pipe_hazard_unit_if.sv
// Decode-stage hazard handshake between the decode/issue logic and the hazard unit.
// The forwarding-select width tracks the number of memory stages.
interface pipe_hazard_unit_if #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RW      = 5
);
  localparam int unsigned FW = $clog2(MEM_LAT + 3);

  logic          d_valid;
  logic [RW-1:0] d_rs;
  logic [RW-1:0] d_rt;
  logic          d_use_rs;
  logic          d_use_rt;
  logic          d_wreg;
  logic          d_m2reg;
  logic [RW-1:0] d_rn;
  logic          d_redirect;

  logic          wpcir;
  logic          e_bubble;
  logic          flush_f;
  logic [FW-1:0] fwda;
  logic [FW-1:0] fwdb;
  logic [15:0]   stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_wreg, d_m2reg, d_rn, d_redirect,
    input  wpcir, e_bubble, flush_f, fwda, fwdb, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_wreg, d_m2reg, d_rn, d_redirect,
    output wpcir, e_bubble, flush_f, fwda, fwdb, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight producers E..W and decides stall,
// bubble, IF flush and per-source forwarding for the instruction in decode.
module pipe_hazard_unit #(
  parameter int unsigned MEM_LAT = 1,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned RW      = 5
) (
  input logic              clock,
  input logic              resetn,
  pipe_hazard_unit_if.slave hz
);
  localparam int unsigned DEPTH = MEM_LAT + 2;
  localparam int unsigned FW    = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] LastMem = FW'(MEM_LAT);

  logic [DEPTH-1:0] vld_q, wreg_q, m2reg_q;
  logic [RW-1:0]    rn_q [DEPTH];
  logic [15:0]      stall_cnt_q;

  logic [1:0]    use_s;
  logic [RW-1:0] src_s [2];
  logic [1:0]    hit, hit_load, blk;
  logic [FW-1:0] idx [2];
  logic [FW-1:0] fwd [2];
  logic          wpcir, issue;

  assign use_s    = {hz.d_use_rt, hz.d_use_rs};
  assign src_s[0] = hz.d_rs;
  assign src_s[1] = hz.d_rt;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s]      = 1'b0;
      hit_load[s] = 1'b0;
      idx[s]      = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (use_s[s] && vld_q[i] && wreg_q[i] && (rn_q[i] != '0) && (rn_q[i] == src_s[s])) begin
          hit[s]      = 1'b1;
          hit_load[s] = m2reg_q[i];
          idx[s]      = FW'(i);
        end
      end
      if (FWD_EN) begin
        blk[s] = hit[s] && hit_load[s] && (idx[s] < LastMem);
        fwd[s] = hit[s] ? idx[s] + 1'b1 : '0;
      end else begin
        // Without bypass only a W-stage producer is safe: the register file writes first.
        blk[s] = hit[s] && (idx[s] <= LastMem);
        fwd[s] = '0;
      end
    end
  end

  assign wpcir = !(hz.d_valid && (|blk));
  assign issue = hz.d_valid && wpcir;

  assign hz.wpcir     = wpcir;
  assign hz.e_bubble  = !issue;
  assign hz.flush_f   = hz.d_redirect && wpcir;
  assign hz.fwda      = fwd[0];
  assign hz.fwdb      = fwd[1];
  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      wreg_q  <= '0;
      m2reg_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rn_q[i] <= '0;
      end
    end else begin
      vld_q   <= {vld_q[DEPTH-2:0], issue};
      wreg_q  <= {wreg_q[DEPTH-2:0], issue && hz.d_wreg};
      m2reg_q <= {m2reg_q[DEPTH-2:0], issue && hz.d_m2reg};
      rn_q[0] <= issue ? hz.d_rn : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        rn_q[i] <= rn_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (!wpcir && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: four configurations share one stimulus
// source selected by 'sel'; a negedge monitor pops expectations and compares.
module tb_pipe_hazard_unit;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int         sel = 0;
  logic       s_valid = 0, s_use_rs = 0, s_use_rt = 0, s_wreg = 0, s_m2reg = 0, s_redirect = 0;
  logic [4:0] s_rs = 0, s_rt = 0, s_rn = 0;

  // 0: MEM_LAT=1 fwd, 1: MEM_LAT=3 fwd, 2: MEM_LAT=1 no fwd, 3: MEM_LAT=4 no fwd
  pipe_hazard_unit_if #(.MEM_LAT(1), .RW(5)) hz0 ();
  pipe_hazard_unit_if #(.MEM_LAT(3), .RW(5)) hz1 ();
  pipe_hazard_unit_if #(.MEM_LAT(1), .RW(5)) hz2 ();
  pipe_hazard_unit_if #(.MEM_LAT(4), .RW(5)) hz3 ();

  pipe_hazard_unit #(.MEM_LAT(1), .FWD_EN(1'b1), .RW(5)) dut0 (.clock(clock), .resetn(resetn), .hz(hz0));
  pipe_hazard_unit #(.MEM_LAT(3), .FWD_EN(1'b1), .RW(5)) dut1 (.clock(clock), .resetn(resetn), .hz(hz1));
  pipe_hazard_unit #(.MEM_LAT(1), .FWD_EN(1'b0), .RW(5)) dut2 (.clock(clock), .resetn(resetn), .hz(hz2));
  pipe_hazard_unit #(.MEM_LAT(4), .FWD_EN(1'b0), .RW(5)) dut3 (.clock(clock), .resetn(resetn), .hz(hz3));

  assign hz0.d_valid = s_valid && (sel == 0);  assign hz0.d_redirect = s_redirect && (sel == 0);
  assign hz1.d_valid = s_valid && (sel == 1);  assign hz1.d_redirect = s_redirect && (sel == 1);
  assign hz2.d_valid = s_valid && (sel == 2);  assign hz2.d_redirect = s_redirect && (sel == 2);
  assign hz3.d_valid = s_valid && (sel == 3);  assign hz3.d_redirect = s_redirect && (sel == 3);
  assign hz0.d_rs = s_rs; assign hz0.d_rt = s_rt; assign hz0.d_rn = s_rn;
  assign hz1.d_rs = s_rs; assign hz1.d_rt = s_rt; assign hz1.d_rn = s_rn;
  assign hz2.d_rs = s_rs; assign hz2.d_rt = s_rt; assign hz2.d_rn = s_rn;
  assign hz3.d_rs = s_rs; assign hz3.d_rt = s_rt; assign hz3.d_rn = s_rn;
  assign hz0.d_use_rs = s_use_rs; assign hz0.d_use_rt = s_use_rt;
  assign hz1.d_use_rs = s_use_rs; assign hz1.d_use_rt = s_use_rt;
  assign hz2.d_use_rs = s_use_rs; assign hz2.d_use_rt = s_use_rt;
  assign hz3.d_use_rs = s_use_rs; assign hz3.d_use_rt = s_use_rt;
  assign hz0.d_wreg = s_wreg; assign hz0.d_m2reg = s_m2reg;
  assign hz1.d_wreg = s_wreg; assign hz1.d_m2reg = s_m2reg;
  assign hz2.d_wreg = s_wreg; assign hz2.d_m2reg = s_m2reg;
  assign hz3.d_wreg = s_wreg; assign hz3.d_m2reg = s_m2reg;

  logic        m_wp, m_bub, m_fl;
  logic [2:0]  m_fa, m_fb;
  logic [15:0] m_cnt;

  always_comb begin
    m_wp = hz0.wpcir; m_bub = hz0.e_bubble; m_fl = hz0.flush_f;
    m_fa = 3'(hz0.fwda); m_fb = 3'(hz0.fwdb); m_cnt = hz0.stall_cnt;
    case (sel)
      1: begin m_wp = hz1.wpcir; m_bub = hz1.e_bubble; m_fl = hz1.flush_f;
               m_fa = hz1.fwda; m_fb = hz1.fwdb; m_cnt = hz1.stall_cnt; end
      2: begin m_wp = hz2.wpcir; m_bub = hz2.e_bubble; m_fl = hz2.flush_f;
               m_fa = 3'(hz2.fwda); m_fb = 3'(hz2.fwdb); m_cnt = hz2.stall_cnt; end
      3: begin m_wp = hz3.wpcir; m_bub = hz3.e_bubble; m_fl = hz3.flush_f;
               m_fa = hz3.fwda; m_fb = hz3.fwdb; m_cnt = hz3.stall_cnt; end
      default: ;
    endcase
  end

  typedef struct {
    int          tag;
    logic        wp, bub, fl;
    bit          cf;
    logic [2:0]  fa, fb;
    bit          cc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input int tag, input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL tag=%0d %s got=%0h exp=%0h", tag, name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "wpcir", 16'(m_wp), 16'(e.wp));
      chk(e.tag, "e_bubble", 16'(m_bub), 16'(e.bub));
      chk(e.tag, "flush_f", 16'(m_fl), 16'(e.fl));
      if (e.cf) begin
        chk(e.tag, "fwda", 16'(m_fa), 16'(e.fa));
        chk(e.tag, "fwdb", 16'(m_fb), 16'(e.fb));
      end
      if (e.cc) chk(e.tag, "stall_cnt", m_cnt, e.cnt);
    end
  end

  task automatic instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic wreg, input logic m2reg, input logic [4:0] rn);
    s_valid = 1; s_rs = rs; s_use_rs = urs; s_rt = rt; s_use_rt = urt;
    s_wreg = wreg; s_m2reg = m2reg; s_rn = rn;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc(input int tag, input logic wp, input logic [2:0] fa, input logic [2:0] fb,
                     input bit cf, input logic [15:0] cnt, input bit cc);
    exp_t e;
    e.tag = tag; e.wp = wp; e.bub = !(s_valid && wp); e.fl = s_redirect && wp;
    e.cf = cf; e.fa = fa; e.fb = fb; e.cc = cc; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 0; s_redirect = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    @(posedge clock); #1;
    // Reset held: no hazards, bubble/flush follow the raw inputs
    instr(1, 0, 2, 0, 1, 1, 3); s_redirect = 1;
    cyc(0, 1, 0, 0, 1, 0, 1);
    resetn = 1;
    idle(2);

    // MEM_LAT=1 with forwarding
    sel = 0;
    instr(1, 1, 2, 1, 1, 0, 3);  cyc(1, 1, 0, 0, 1, 0, 1);
    instr(3, 1, 3, 1, 1, 0, 4);  cyc(2, 1, 1, 1, 1, 0, 0);
    instr(3, 1, 0, 1, 1, 0, 5);  cyc(3, 1, 2, 0, 1, 0, 0);
    idle(3);
    instr(1, 1, 0, 0, 1, 1, 2);  cyc(4, 1, 0, 0, 1, 0, 1);
    instr(2, 1, 1, 1, 1, 0, 6);  cyc(5, 0, 0, 0, 0, 0, 1);
                                 cyc(6, 1, 2, 0, 1, 1, 1);
    idle(3);
    instr(1, 1, 0, 0, 1, 1, 0);  cyc(7, 1, 0, 0, 1, 1, 1);
    instr(0, 1, 0, 1, 1, 0, 6);  cyc(8, 1, 0, 0, 1, 1, 1);
    instr(1, 1, 2, 1, 0, 1, 5);  cyc(9, 1, 0, 0, 1, 1, 0);
    instr(5, 1, 5, 1, 1, 0, 9);  cyc(10, 1, 0, 0, 1, 1, 0);
    instr(1, 1, 2, 1, 1, 0, 9);  cyc(11, 1, 0, 0, 1, 1, 0);
    instr(9, 1, 9, 1, 1, 0, 10); cyc(12, 1, 1, 1, 1, 1, 1);
    idle(3);

    // MEM_LAT=3 with forwarding: load-use back to back, then with two fillers
    sel = 1;
    instr(1, 1, 0, 0, 1, 1, 7);  cyc(13, 1, 0, 0, 1, 0, 1);
    instr(0, 1, 7, 1, 1, 0, 8);  cyc(14, 0, 0, 0, 0, 0, 1);
                                 cyc(15, 0, 0, 0, 0, 1, 1);
                                 cyc(16, 0, 0, 0, 0, 2, 1);
                                 cyc(17, 1, 0, 4, 1, 3, 1);
    idle(5);
    instr(1, 1, 0, 0, 1, 1, 7);  cyc(18, 1, 0, 0, 1, 3, 1);
    instr(1, 1, 2, 1, 1, 0, 11); cyc(19, 1, 0, 0, 1, 3, 0);
    instr(1, 1, 2, 1, 1, 0, 12); cyc(20, 1, 0, 0, 1, 3, 0);
    instr(0, 1, 7, 1, 1, 0, 8);  cyc(21, 0, 0, 0, 0, 3, 1);
                                 cyc(22, 1, 0, 4, 1, 4, 1);
    idle(5);

    // MEM_LAT=1 without forwarding, redirect held across the stall
    sel = 2;
    instr(1, 1, 2, 1, 1, 0, 3);  cyc(23, 1, 0, 0, 1, 0, 1);
    instr(3, 1, 1, 1, 1, 0, 4);  s_redirect = 1;
                                 cyc(24, 0, 0, 0, 0, 0, 1);
                                 cyc(25, 0, 0, 0, 0, 1, 1);
                                 cyc(26, 1, 0, 0, 1, 2, 1);
    idle(3);

    // Self-dependent load loop on MEM_LAT=4/no-fwd: 5 stalls per issue until saturation
    sel = 3;
    instr(7, 1, 0, 0, 1, 1, 7);  cyc(27, 1, 0, 0, 1, 0, 1);
    repeat (78700) @(posedge clock);
    #1;
    idle(8);                     cyc(28, 1, 0, 0, 1, 16'hFFFF, 1);
    instr(7, 1, 0, 0, 1, 1, 7);  cyc(29, 1, 0, 0, 1, 16'hFFFF, 1);
                                 cyc(30, 0, 0, 0, 0, 16'hFFFF, 1);
    resetn = 0;                  cyc(31, 1, 0, 0, 1, 0, 1);
    resetn = 1;                  cyc(32, 1, 0, 0, 1, 0, 1);
                                 cyc(33, 0, 0, 0, 0, 0, 1);
                                 cyc(34, 0, 0, 0, 0, 1, 1);
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter MEM_LAT, default 1, number of memory stages (1..4); load data is forwardable from the last memory stage.
REQ-002 Parameter FWD_EN, default 1, 1 = forwarding enabled, 0 = stall on every in-flight producer.
REQ-003 Parameter RW, default 5, register-number width; register 0 is never a producer.
REQ-004 Local DEPTH = MEM_LAT+2 tracked stages, index 0 = E, 1..MEM_LAT = M1..Mn, MEM_LAT+1 = W; FW = clog2(DEPTH+1).
REQ-005 clock  in  1  single rising-edge clock.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 d_valid  in  1  decode stage holds a real instruction.
REQ-008 d_rs, d_rt  in  RW each  decode source register numbers.
REQ-009 d_use_rs, d_use_rt  in  1 each  instruction reads that source.
REQ-010 d_wreg  in  1  instruction writes a register.
REQ-011 d_m2reg  in  1  instruction is a load.
REQ-012 d_rn  in  RW  destination register number.
REQ-013 d_redirect  in  1  decode resolved jump/taken branch.
REQ-014 wpcir  out  1  0 = hold PC and IF/ID register.
REQ-015 e_bubble  out  1  1 = E stage receives a bubble this cycle.
REQ-016 flush_f  out  1  1 = squash instruction in IF.
REQ-017 fwda, fwdb  out  FW each  0 = register file, k = result of stage k-1.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Unit SHALL keep a DEPTH-entry shift chain; each entry holds valid, wreg, m2reg, rn.
REQ-020 Each clock, entry i SHALL move to i+1, and entry DEPTH-1 SHALL be discarded.
REQ-021 Entry 0 SHALL load {1, d_wreg, d_m2reg, d_rn} when issue = d_valid & wpcir; otherwise it SHALL load all-zero (bubble).
REQ-022 A source SHALL match entry i when: the source is used; entry i has valid & wreg; rn != 0; and rn equals the source.
REQ-023 Only the youngest (lowest index) matching entry SHALL count for each source.
REQ-024 With FWD_EN=1, the source SHALL be blocked when its youngest match is a load with i < MEM_LAT.
REQ-025 With FWD_EN=1, any other match SHALL set fwd = i+1.
REQ-026 With FWD_EN=0, the source SHALL be blocked when a match exists with i <= MEM_LAT.
REQ-027 With FWD_EN=0, a match only at W SHALL give fwd = 0 (register file is write-first).
REQ-028 With no match, fwd SHALL be 0.
REQ-029 wpcir SHALL be 0 when d_valid and either source is blocked; otherwise wpcir SHALL be 1.
REQ-030 e_bubble SHALL equal ~issue.
REQ-031 All outputs SHALL be combinational from state and inputs with zero latency; only the chain and stall_cnt are registered.
REQ-032 A load in E needs MEM_LAT stall cycles before a dependent instruction issues (1 cycle when MEM_LAT=1).
REQ-033 flush_f SHALL equal d_redirect & wpcir; a redirect during a stall SHALL be ignored until the stall clears.
REQ-034 stall_cnt SHALL increment on every clock with wpcir=0 and SHALL hold at 16'hFFFF.
REQ-035 The fwd value SHALL be valid only when wpcir=1; fwd contents while stalled are don't-care.

Reset
REQ-036 resetn=0 SHALL immediately clear all chain entries and stall_cnt, independent of clock.
REQ-037 During reset, outputs SHALL read wpcir=1, fwda=fwdb=0, e_bubble=~d_valid, flush_f=d_redirect, stall_cnt=0.
REQ-038 Reset asserted mid-stall SHALL release the stall in the same cycle; the first issue after deassertion sees no hazards.

Verification
REQ-039 MEM_LAT=1, FWD_EN=1: add r3 then add r4,r3,r3 -> no stall, fwda=fwdb=1; next add r5,r3,r0 -> fwda=2.
REQ-040 MEM_LAT=1: lw r2 then sub r6,r2,r1 -> wpcir=0, e_bubble=1 for 1 cycle, then fwda=2, stall_cnt=1.
REQ-041 MEM_LAT=3: lw r7 then or r8,r0,r7 -> 3 stall cycles, then fwdb=4; with 2 unrelated instructions between them -> 1 stall.
REQ-042 Producer writing r0 or with d_wreg=0 -> never stalls or forwards; two producers of r9 in E and M1 -> fwd selects E (1).
REQ-043 FWD_EN=0, MEM_LAT=1: add r3 then use r3 -> 2 stall cycles, then fwd=0; d_redirect during stall -> flush_f=0 until stall clears, then 1.
REQ-044 Force 65540 stall cycles -> stall_cnt=16'hFFFF; resetn pulse mid-stall -> wpcir=1 and stall_cnt=0 immediately.
